// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, one difference bit per clock, LSB first.
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   start    - begin a subtraction (accepted only when idle)
//   A, B     - minuend / subtrahend, captured on the accept edge
//   busy     - operation in progress (RUN or FIN)
//   D_bit    - serial difference bit, qualified by D_valid
//   D_valid  - D_bit valid this cycle
//   D        - parallel difference A-B mod 2^WIDTH, updated with done
//   Bo       - final borrow (A < B unsigned), updated with done
//   done     - one-cycle pulse marking D and Bo valid
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             D_bit,
  output logic             D_valid,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             busy_d, dbit_d, dvalid_d, bo_d, done_d;
  logic [WIDTH-1:0] d_d;

  // Current bit pair and full-subtractor terms for the RUN cycle
  logic a_bit, b_bit, diff_bit, borrow_nxt;
  assign a_bit      = a_q[0];
  assign b_bit      = b_q[0];
  assign diff_bit   = a_bit ^ b_bit ^ borrow_q;
  assign borrow_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      D_bit    <= 1'b0;
      D_valid  <= 1'b0;
      D        <= '0;
      Bo       <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      busy     <= busy_d;
      D_bit    <= dbit_d;
      D_valid  <= dvalid_d;
      D        <= d_d;
      Bo       <= bo_d;
      done     <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    dbit_d   = 1'b0;
    dvalid_d = 1'b0;
    d_d      = D;
    bo_d     = Bo;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        dbit_d   = diff_bit;
        dvalid_d = 1'b1;
        // Result fills from the top so bit 0 lands at the LSB after WIDTH shifts
        res_d    = {diff_bit, res_q[WIDTH-1:1]};
        borrow_d = borrow_nxt;
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN: begin
        done_d  = 1'b1;
        d_d     = res_q;
        bo_d    = borrow_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
